// File: rtl/usb_tx_pkg.sv
// Shared constants and state encoding for the USB transmit bit engine.
// Consumed by usb_tx_bit_encoder and nrzi_encoder_cell.
package usb_tx_pkg;

  // Idle line level: J (D+ high on a full-speed link).
  localparam logic J_LEVEL = 1'b1;

  // EOP is this many SE0 bit times followed by one J bit time.
  localparam int unsigned EOP_SE0_BITS = 2;

  localparam int unsigned DEF_STUFF_LIMIT = 6;
  localparam int unsigned DEF_SYNC_LEN    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STUFF   = 3'd3;
  localparam logic [2:0] ST_EOP_SE0 = 3'd4;
  localparam logic [2:0] ST_EOP_J   = 3'd5;

  typedef enum logic [2:0] {
    TX_IDLE    = ST_IDLE,
    TX_SYNC    = ST_SYNC,
    TX_DATA    = ST_DATA,
    TX_STUFF   = ST_STUFF,
    TX_EOP_SE0 = ST_EOP_SE0,
    TX_EOP_J   = ST_EOP_J
  } tx_state_t;

endpackage

// File: rtl/nrzi_encoder_cell.sv
// NRZI line register: a 0 toggles the level, a 1 holds it; updates only on
// bit-time strobes. force_j_i parks the line at J regardless of the bit.
module nrzi_encoder_cell
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic nRST,
  input  logic pulse,
  input  logic bit_en_i,
  input  logic bit_i,
  input  logic force_j_i,
  output logic level_o
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level_q;
    if (pulse) begin
      if (force_j_i) begin
        level_d = J_LEVEL;
      end else if (bit_en_i && !bit_i) begin
        level_d = ~level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      level_q <= J_LEVEL;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/usb_tx_bit_encoder.sv
// USB transmit bit engine: optional SYNC, bit stuffing, NRZI and EOP.
// Define TX_SYNC_GEN_EN to have the block generate the SYNC field itself.
module usb_tx_bit_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT = DEF_STUFF_LIMIT,
  parameter int unsigned SYNC_LEN    = DEF_SYNC_LEN
) (
  input  logic clk,
  input  logic nRST,
  input  logic pulse,
  input  logic tx_start,
  input  logic tx_bit_valid,
  input  logic tx_bit,
  input  logic tx_last,
  output logic tx_bit_ack,
  output logic encoded_bit,
  output logic se0,
  output logic tx_oe,
  output logic tx_busy,
  output logic tx_underrun
);

  localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned EW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [OW-1:0] LIMIT_C    = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] SE0_LAST_C = EW'(EOP_SE0_BITS - 1);

  if (STUFF_LIMIT < 1 || SYNC_LEN < 2) begin : g_param_check
    $error("usb_tx_bit_encoder: STUFF_LIMIT must be >= 1 and SYNC_LEN >= 2");
  end

`ifdef TX_SYNC_GEN_EN
  localparam int unsigned SW = $clog2(SYNC_LEN);
  localparam logic [SW-1:0] SYNC_LAST_C = SW'(SYNC_LEN - 1);
  localparam logic [2:0]    FIRST_ST    = ST_SYNC;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
`else
  localparam logic [2:0]    FIRST_ST    = ST_DATA;
`endif

  logic [2:0]    state_q, state_d;
  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic          last_pend_q, last_pend_d;
  logic          se0_q, se0_d;
  logic          oe_q, oe_d;
  logic          underrun_q, underrun_d;

  logic          bit_en;
  logic          line_bit;
  logic          force_j;
  logic [OW-1:0] ones_inc;

  assign ones_inc   = ones_cnt_q + OW'(1);
  assign tx_bit_ack = pulse && (state_q == ST_DATA) && tx_bit_valid &&
                      (ones_cnt_q != LIMIT_C);

  // NOTE: every signal written here gets a default first; a path that
  // forgets one would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    eop_cnt_d   = eop_cnt_q;
    last_pend_d = last_pend_q;
    se0_d       = se0_q;
    oe_d        = oe_q;
    underrun_d  = 1'b0;
    bit_en      = 1'b0;
    line_bit    = 1'b1;
    force_j     = 1'b0;
`ifdef TX_SYNC_GEN_EN
    sync_cnt_d  = sync_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = FIRST_ST;
        end
      end

`ifdef TX_SYNC_GEN_EN
      ST_SYNC: begin
        if (pulse) begin
          oe_d       = 1'b1;
          bit_en     = 1'b1;
          line_bit   = (sync_cnt_q == SYNC_LAST_C);
          ones_cnt_d = line_bit ? ones_inc : '0;
          if (sync_cnt_q == SYNC_LAST_C) begin
            sync_cnt_d = '0;
            state_d    = (line_bit && ones_inc == LIMIT_C) ? ST_STUFF : ST_DATA;
          end else begin
            sync_cnt_d = sync_cnt_q + SW'(1);
          end
        end
      end
`endif

      ST_DATA: begin
        if (pulse) begin
          oe_d = 1'b1;
          if (ones_cnt_q == LIMIT_C) begin
            bit_en     = 1'b1;
            line_bit   = 1'b0;
            ones_cnt_d = '0;
          end else if (tx_bit_ack) begin
            bit_en     = 1'b1;
            line_bit   = tx_bit;
            ones_cnt_d = tx_bit ? ones_inc : '0;
            // The last bit may still owe a stuffed zero before EOP.
            if (tx_bit && ones_inc == LIMIT_C) begin
              state_d     = ST_STUFF;
              last_pend_d = tx_last;
            end else if (tx_last) begin
              state_d = ST_EOP_SE0;
            end
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_EOP_SE0;
          end
        end
      end

      ST_STUFF: begin
        if (pulse) begin
          oe_d        = 1'b1;
          bit_en      = 1'b1;
          line_bit    = 1'b0;
          ones_cnt_d  = '0;
          last_pend_d = 1'b0;
          state_d     = last_pend_q ? ST_EOP_SE0 : ST_DATA;
        end
      end

      ST_EOP_SE0: begin
        if (pulse) begin
          oe_d  = 1'b1;
          se0_d = 1'b1;
          if (eop_cnt_q == SE0_LAST_C) begin
            eop_cnt_d = '0;
            state_d   = ST_EOP_J;
          end else begin
            eop_cnt_d = eop_cnt_q + EW'(1);
          end
        end
      end

      ST_EOP_J: begin
        // First strobe drives J, second releases the driver.
        if (pulse) begin
          se0_d = 1'b0;
          if (eop_cnt_q == '0) begin
            oe_d      = 1'b1;
            force_j   = 1'b1;
            eop_cnt_d = EW'(1);
          end else begin
            oe_d       = 1'b0;
            eop_cnt_d  = '0;
            ones_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      ones_cnt_q  <= '0;
      eop_cnt_q   <= '0;
      last_pend_q <= 1'b0;
      se0_q       <= 1'b0;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
      last_pend_q <= last_pend_d;
      se0_q       <= se0_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef TX_SYNC_GEN_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_cnt_q <= '0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
    end
  end
`endif

  nrzi_encoder_cell u_nrzi (
    .clk       (clk),
    .nRST      (nRST),
    .pulse     (pulse),
    .bit_en_i  (bit_en),
    .bit_i     (line_bit),
    .force_j_i (force_j),
    .level_o   (encoded_bit)
  );

  assign se0         = se0_q;
  assign tx_oe       = oe_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_underrun = underrun_q;

endmodule
